gate_reduce_acc: RTL and testbench

//   Parametrised successor to the lab 2-input OR gate: a sequential, handshaked

---
 rtl/gate_reduce_acc_if.sv | 29 ++
 rtl/gate_reduce_acc.sv | 129 ++++++++++++
 tb/tb_gate_reduce_acc.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_reduce_acc_if.sv
// Valid/ready bundle between the word source, the reduction unit and the result sink.
// The slave modport is the reduction unit's view of the bundle.
interface gate_reduce_acc_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int CW = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, op, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, op, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/gate_reduce_acc.sv
// Handshaked bitwise reduction unit: folds a burst of words with OR/AND/XOR/NOR
// and presents one registered result, beat count and overflow flag per burst.
//
// state  | meaning
// S_IDLE | waiting for the first beat of a burst
// S_ACC  | burst in progress, folding later beats into the accumulator
// S_HOLD | result registered, waiting for the sink to take it
module gate_reduce_acc #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_reduce_acc_if.slave   bus
);
    localparam int            CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_NOR = 2'd3
    } op_t;

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_out_count;
    logic             r_out_ovf;

    logic             w_beat;
    logic             w_first;
    op_t              w_op;
    logic [WIDTH-1:0] w_fold;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_ovf_nxt;
    logic [WIDTH-1:0] w_result;

    // The first beat seeds the accumulator and uses the live op; later beats use the latched op.
    always_comb begin
        w_beat    = bus.in_valid && r_in_ready;
        w_first   = (r_state == S_IDLE);
        w_op      = w_first ? op_t'(bus.op) : r_op;
        w_fold    = bus.in_data;
        w_cnt_nxt = CNT_ONE;
        w_ovf_nxt = 1'b0;
        if (!w_first) begin
            case (r_op)
                OP_AND:  w_fold = r_acc & bus.in_data;
                OP_XOR:  w_fold = r_acc ^ bus.in_data;
                default: w_fold = r_acc | bus.in_data;
            endcase
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
            w_ovf_nxt = r_ovf || (r_cnt == CNT_MAX);
        end
        w_result = (w_op == OP_NOR) ? ~w_fold : w_fold;
    end

    // in_ready is registered so that it stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_OR;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    r_in_ready <= 1'b1;
                    if (w_beat) begin
                        r_acc <= w_fold;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                        if (w_first) begin
                            r_op <= op_t'(bus.op);
                        end
                        if (bus.in_last) begin
                            r_out_data  <= w_result;
                            r_out_count <= w_cnt_nxt;
                            r_out_ovf   <= w_ovf_nxt;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_gate_reduce_acc.sv
// Self-checking bench for gate_reduce_acc with directed scenarios and random bursts
// compared against a fold-over-a-list reference model.
module tb_gate_reduce_acc;
    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_reduce_acc_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bif ();

    gate_reduce_acc #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] words[16];

    // Reference: fold the word list left to right, invert at the end for NOR.
    function automatic void model(input logic [1:0] op, input int n,
                                  output logic [WIDTH-1:0] d, output logic [CW-1:0] c,
                                  output logic ovf);
        logic [WIDTH-1:0] acc;
        acc = words[0];
        for (int i = 1; i < n; i++) begin
            case (op)
                2'd1:    acc = acc & words[i];
                2'd2:    acc = acc ^ words[i];
                default: acc = acc | words[i];
            endcase
        end
        d   = (op == 2'd3) ? ~acc : acc;
        c   = CW'((n > MAX_LEN) ? MAX_LEN : n);
        ovf = (n > MAX_LEN);
    endfunction

    // Drives words[0..n-1]; returns just after the edge that accepted the final beat.
    task automatic send_beats(input logic [1:0] op0, input int n, input bit bubbles,
                              input bit scramble_op, input bit no_last, output bit to);
        int k;
        to = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                bif.in_valid = 1'b0;
                bif.in_last  = 1'($urandom_range(0, 1));
                bif.in_data  = WIDTH'($urandom);
                @(posedge clk);
            end
            @(negedge clk);
            bif.in_valid = 1'b1;
            bif.in_data  = words[i];
            bif.in_last  = (i == n - 1) && !no_last;
            bif.op       = (i == 0 || !scramble_op) ? op0 : 2'($urandom);
            k = 0;
            while (bif.in_ready !== 1'b1 && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (k == 50) to = 1'b1;
            @(posedge clk);
        end
        #1;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic take_result();
        @(negedge clk);
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks += 5;
        if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bif.in_ready); end
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bif.out_valid); end
        if (bif.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 00", bif.out_data); end
        if (bif.out_count !== '0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", bif.out_count); end
        if (bif.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got %b want 0", bif.out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bif.in_ready); end
    endtask

    task automatic test_or();
        bit to;
        words[0] = 8'h01; words[1] = 8'h10; words[2] = 8'h80;
        send_beats(2'd0, 3, 1'b0, 1'b0, 1'b0, to);
        n_checks += 5;
        if (to !== 1'b0) begin n_fail++; $display("FAIL or_timeout got %b want 0", to); end
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL or_latency out_valid got %b want 1", bif.out_valid); end
        if (bif.out_data !== 8'h91) begin n_fail++; $display("FAIL or_data got %h want 91", bif.out_data); end
        if (bif.out_count !== CW'(3)) begin n_fail++; $display("FAIL or_count got %0d want 3", bif.out_count); end
        if (bif.out_ovf !== 1'b0) begin n_fail++; $display("FAIL or_ovf got %b want 0", bif.out_ovf); end
        take_result();
        n_checks += 3;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL or_taken_valid got %b want 0", bif.out_valid); end
        if (bif.out_data !== 8'h91) begin n_fail++; $display("FAIL or_retain_data got %h want 91", bif.out_data); end
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL or_taken_in_ready got %b want 1", bif.in_ready); end
    endtask

    task automatic test_back_to_back();
        bit to;
        words[0] = 8'hF0; words[1] = 8'h3C;
        send_beats(2'd1, 2, 1'b0, 1'b1, 1'b0, to);
        n_checks += 3;
        if (to !== 1'b0) begin n_fail++; $display("FAIL and_timeout got %b want 0", to); end
        if (bif.out_data !== 8'h30) begin n_fail++; $display("FAIL and_data got %h want 30", bif.out_data); end
        if (bif.out_count !== CW'(2)) begin n_fail++; $display("FAIL and_count got %0d want 2", bif.out_count); end
        take_result();
        words[0] = 8'hAA; words[1] = 8'hFF;
        send_beats(2'd2, 2, 1'b0, 1'b1, 1'b0, to);
        n_checks += 2;
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL xor_valid got %b want 1", bif.out_valid); end
        if (bif.out_data !== 8'h55) begin n_fail++; $display("FAIL xor_data got %h want 55", bif.out_data); end
        take_result();
    endtask

    task automatic test_nor_single();
        bit to;
        words[0] = 8'h0F;
        send_beats(2'd3, 1, 1'b0, 1'b0, 1'b0, to);
        n_checks += 2;
        if (bif.out_data !== 8'hF0) begin n_fail++; $display("FAIL nor_data got %h want F0", bif.out_data); end
        if (bif.out_count !== CW'(1)) begin n_fail++; $display("FAIL nor_count got %0d want 1", bif.out_count); end
        take_result();
        send_beats(2'd0, 1, 1'b0, 1'b0, 1'b0, to);
        n_checks++;
        if (bif.out_data !== 8'h0F) begin n_fail++; $display("FAIL or_single_data got %h want 0F", bif.out_data); end
        take_result();
    endtask

    task automatic test_backpressure();
        bit to;
        words[0] = 8'h11; words[1] = 8'h22;
        send_beats(2'd0, 2, 1'b0, 1'b0, 1'b0, to);
        @(negedge clk);
        bif.in_valid = 1'b1; bif.in_data = 8'hEE; bif.in_last = 1'b1; bif.op = 2'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, bif.in_ready); end
            if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b want 1", c, bif.out_valid); end
            if (bif.out_data !== 8'h33) begin n_fail++; $display("FAIL bp_data cyc %0d got %h want 33", c, bif.out_data); end
            if (bif.out_count !== CW'(2)) begin n_fail++; $display("FAIL bp_count cyc %0d got %0d want 2", c, bif.out_count); end
        end
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.out_ready = 1'b0;
        n_checks += 2;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", bif.out_valid); end
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", bif.in_ready); end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0; bif.in_last = 1'b0;
        n_checks += 3;
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %b want 1", bif.out_valid); end
        if (bif.out_data !== 8'hEE) begin n_fail++; $display("FAIL bp_next_data got %h want EE", bif.out_data); end
        if (bif.out_count !== CW'(1)) begin n_fail++; $display("FAIL bp_next_count got %0d want 1", bif.out_count); end
        take_result();
    endtask

    task automatic test_overflow();
        bit to;
        for (int i = 0; i < 6; i++) words[i] = 8'h01;
        send_beats(2'd0, 6, 1'b0, 1'b0, 1'b0, to);
        n_checks += 3;
        if (bif.out_data !== 8'h01) begin n_fail++; $display("FAIL ovf_data got %h want 01", bif.out_data); end
        if (bif.out_count !== CW'(MAX_LEN)) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", bif.out_count, MAX_LEN); end
        if (bif.out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", bif.out_ovf); end
        take_result();
        words[0] = 8'h03; words[1] = 8'h04;
        send_beats(2'd0, 2, 1'b0, 1'b0, 1'b0, to);
        n_checks += 3;
        if (bif.out_data !== 8'h07) begin n_fail++; $display("FAIL ovf_next_data got %h want 07", bif.out_data); end
        if (bif.out_count !== CW'(2)) begin n_fail++; $display("FAIL ovf_next_count got %0d want 2", bif.out_count); end
        if (bif.out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag got %b want 0", bif.out_ovf); end
        take_result();
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        words[0] = 8'hC3; words[1] = 8'h81;
        send_beats(2'd0, 2, 1'b0, 1'b0, 1'b1, to);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (bif.out_data !== '0) begin n_fail++; $display("FAIL rst_mid_data got %h want 00", bif.out_data); end
        if (bif.out_count !== '0) begin n_fail++; $display("FAIL rst_mid_count got %0d want 0", bif.out_count); end
        if (bif.out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf got %b want 0", bif.out_ovf); end
        if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 0", bif.in_ready); end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", bif.out_valid); end
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_valid got %b want 0", bif.out_valid); end
        end
        words[0] = 8'h5A;
        send_beats(2'd2, 1, 1'b0, 1'b0, 1'b0, to);
        n_checks += 3;
        if (to !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_timeout got %b want 0", to); end
        if (bif.out_data !== 8'h5A) begin n_fail++; $display("FAIL rst_fresh_data got %h want 5A", bif.out_data); end
        if (bif.out_count !== CW'(1)) begin n_fail++; $display("FAIL rst_fresh_count got %0d want 1", bif.out_count); end
        take_result();
    endtask

    task automatic test_random();
        bit               to;
        int               n;
        int               hold;
        logic [1:0]       op;
        logic [WIDTH-1:0] e_d;
        logic [CW-1:0]    e_c;
        logic             e_o;
        for (int b = 0; b < 40; b++) begin
            n  = $urandom_range(1, 7);
            op = 2'($urandom);
            for (int i = 0; i < n; i++) words[i] = WIDTH'($urandom);
            model(op, n, e_d, e_c, e_o);
            send_beats(op, n, 1'b1, 1'b1, 1'b0, to);
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            n_checks += 5;
            if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout got %b want 0", b, to); end
            if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL rand%0d_valid got %b want 1", b, bif.out_valid); end
            if (bif.out_data !== e_d) begin n_fail++; $display("FAIL rand%0d_data op %0d n %0d got %h want %h", b, op, n, bif.out_data, e_d); end
            if (bif.out_count !== e_c) begin n_fail++; $display("FAIL rand%0d_count got %0d want %0d", b, bif.out_count, e_c); end
            if (bif.out_ovf !== e_o) begin n_fail++; $display("FAIL rand%0d_ovf got %b want %b", b, bif.out_ovf, e_o); end
            take_result();
        end
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.in_last   = 1'b0;
        bif.op        = 2'd0;
        bif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_or();
        test_back_to_back();
        test_nor_single();
        test_backpressure();
        test_overflow();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
